// File: rtl/dma_read_engine.sv
// dma_read_engine
//   Responder for the dma_engineer_* weight-fetch interface. Accepts one
//   request (start beat address + beat count), issues beat reads to the
//   external memory port while keeping at most MAX_OUTSTANDING reads in
//   flight, and streams the returned beats back with a last-beat marker.
//
// Configuration macro: DMA_OUTPUT_REG_EN
//   defined   : dout/dout_en/dout_eop are registered (1-cycle latency from
//               mem_rd_dout_en); DRAIN ends after the registered eop beat.
//   undefined : dout/dout_en/dout_eop are a combinational path from the
//               memory read data (0-cycle latency).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   dma_engineer_req          level request, held until ack
//   dma_engineer_start_addr   first beat address (valid with req)
//   dma_engineer_length       number of beats (valid with req)
//   dma_engineer_ack          one-cycle accept pulse
//   dma_engineer_dout(_en)    returned beat and its valid strobe
//   dma_engineer_dout_eop     final beat marker (only with dout_en)
//   mem_rd_en/rdy/addr        read command handshake and beat address
//   mem_rd_dout_en/dout       in-order read data return
module dma_read_engine #(
    parameter int ADDR_W          = 27,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_engineer_req,
    input  logic [ADDR_W-1:0] dma_engineer_start_addr,
    input  logic [ADDR_W-1:0] dma_engineer_length,
    output logic              dma_engineer_ack,
    output logic [DATA_W-1:0] dma_engineer_dout,
    output logic              dma_engineer_dout_en,
    output logic              dma_engineer_dout_eop,
    output logic              mem_rd_en,
    input  logic              mem_rd_rdy,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_dout_en,
    input  logic [DATA_W-1:0] mem_rd_dout
);
    localparam int                OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]  OUT_ONE = OUT_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] remain_r;
    logic [ADDR_W-1:0] beats_r;
    logic [ADDR_W-1:0] rx_cnt_r;
    logic [OUT_W-1:0]  outstanding_r;

    logic              accept_s;
    logic              rx_valid_s;
    logic              last_beat_s;
    logic              drain_done_s;
    logic [ADDR_W-1:0] remain_next_s;
    logic [OUT_W-1:0]  outstanding_next_s;

    // Handshake decode and next-value arithmetic for the issue counters.
    always_comb begin
        accept_s    = mem_rd_en && mem_rd_rdy;
        // Returns outside an active transfer are dropped.
        rx_valid_s  = mem_rd_dout_en && ((state_r == ISSUE) || (state_r == DRAIN));
        last_beat_s = rx_valid_s && (rx_cnt_r == (beats_r - A_ONE));

        if (accept_s) begin
            remain_next_s = remain_r - A_ONE;
        end else begin
            remain_next_s = remain_r;
        end

        if (accept_s && !rx_valid_s) begin
            outstanding_next_s = outstanding_r + OUT_ONE;
        end else if (!accept_s && rx_valid_s && (outstanding_r != {OUT_W{1'b0}})) begin
            outstanding_next_s = outstanding_r - OUT_ONE;
        end else begin
            outstanding_next_s = outstanding_r;
        end

`ifdef DMA_OUTPUT_REG_EN
        // Leave DRAIN only once the registered eop beat is on the outputs.
        drain_done_s = dma_engineer_dout_en && dma_engineer_dout_eop;
`else
        drain_done_s = last_beat_s;
`endif
    end

    // Control FSM; mem_rd_addr doubles as the running beat address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            remain_r         <= {ADDR_W{1'b0}};
            beats_r          <= {ADDR_W{1'b0}};
            rx_cnt_r         <= {ADDR_W{1'b0}};
            outstanding_r    <= {OUT_W{1'b0}};
            dma_engineer_ack <= 1'b0;
            mem_rd_en        <= 1'b0;
            mem_rd_addr      <= {ADDR_W{1'b0}};
        end else begin
            dma_engineer_ack <= 1'b0;
            case (state_r)
                IDLE: begin
                    mem_rd_en <= 1'b0;
                    if (dma_engineer_req) begin
                        mem_rd_addr      <= dma_engineer_start_addr;
                        remain_r         <= dma_engineer_length;
                        beats_r          <= dma_engineer_length;
                        rx_cnt_r         <= {ADDR_W{1'b0}};
                        outstanding_r    <= {OUT_W{1'b0}};
                        dma_engineer_ack <= 1'b1;
                        state_r          <= ACK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACK: begin
                    if (beats_r == {ADDR_W{1'b0}}) begin
                        mem_rd_en <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        mem_rd_en <= 1'b1;
                        state_r   <= ISSUE;
                    end
                end
                ISSUE: begin
                    remain_r      <= remain_next_s;
                    outstanding_r <= outstanding_next_s;
                    if (accept_s) begin
                        mem_rd_addr <= mem_rd_addr + A_ONE;
                    end
                    if (rx_valid_s) begin
                        rx_cnt_r <= rx_cnt_r + A_ONE;
                    end
                    // Registered command valid: look ahead at next-cycle counters.
                    mem_rd_en <= (remain_next_s != {ADDR_W{1'b0}}) &&
                                 (outstanding_next_s < OUT_MAX);
                    if (accept_s && (remain_r == A_ONE)) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                DRAIN: begin
                    mem_rd_en     <= 1'b0;
                    outstanding_r <= outstanding_next_s;
                    if (rx_valid_s) begin
                        rx_cnt_r <= rx_cnt_r + A_ONE;
                    end
                    if (drain_done_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    mem_rd_en <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef DMA_OUTPUT_REG_EN
    // Registered beat output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_engineer_dout     <= {DATA_W{1'b0}};
            dma_engineer_dout_en  <= 1'b0;
            dma_engineer_dout_eop <= 1'b0;
        end else begin
            dma_engineer_dout_en  <= rx_valid_s;
            dma_engineer_dout_eop <= last_beat_s;
            if (rx_valid_s) begin
                dma_engineer_dout <= mem_rd_dout;
            end
        end
    end
`else
    // Combinational beat pass-through, gated by transfer state.
    always_comb begin
        dma_engineer_dout     = mem_rd_dout;
        dma_engineer_dout_en  = rx_valid_s;
        dma_engineer_dout_eop = last_beat_s;
    end
`endif

endmodule

// File: tb/tb_dma_read_engine.sv
// Self-checking bench for dma_read_engine: an in-order memory model with
// programmable latency and random ready, plus a queue-based reference of
// the expected command addresses, beat data and eop positions.
module tb_dma_read_engine;
    localparam int AW      = 27;
    localparam int DW      = 512;
    localparam int MAX_OUT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] length = '0;
    logic          ack;
    logic [DW-1:0] dout;
    logic          dout_en;
    logic          dout_eop;
    logic          mem_rd_en;
    logic          mem_rd_rdy = 1'b1;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_dout_en = 1'b0;
    logic [DW-1:0] mem_rd_dout = '0;

    dma_read_engine #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .dma_engineer_req        (req),
        .dma_engineer_start_addr (start_addr),
        .dma_engineer_length     (length),
        .dma_engineer_ack        (ack),
        .dma_engineer_dout       (dout),
        .dma_engineer_dout_en    (dout_en),
        .dma_engineer_dout_eop   (dout_eop),
        .mem_rd_en               (mem_rd_en),
        .mem_rd_rdy              (mem_rd_rdy),
        .mem_rd_addr             (mem_rd_addr),
        .mem_rd_dout_en          (mem_rd_dout_en),
        .mem_rd_dout             (mem_rd_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = {5'(i), a} ^ (32'h9E37_79B9 * 32'(i + 1));
        end
        return d;
    endfunction

    // memory model state
    int            lat_v = 1;
    bit            rdy_rand = 1'b0;
    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];
    int            tb_out = 0;

    // observed
    logic [AW-1:0] cmd_q[$];
    logic [DW-1:0] beat_q[$];
    logic          eop_q[$];
    int            ack_cyc[$];
    int            eop_cyc[$];
    int            first_en = -1;
    int            last_cmd = -1;

    // expected
    logic [AW-1:0] exp_cmd[$];
    logic [DW-1:0] exp_dat[$];
    logic          exp_eop[$];

    // Memory model and output monitor, mid-cycle.
    always @(negedge clk) begin : mem_mon
        bit ret;
        ret = 1'b0;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            tb_out         = 0;
            mem_rd_dout_en = 1'b0;
            mem_rd_dout    = '0;
            mem_rd_rdy     = 1'b1;
        end else begin
            mem_rd_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                mem_rd_dout_en = 1'b1;
                mem_rd_dout    = mem_data(pend_addr.pop_front());
                void'(pend_due.pop_front());
                ret = 1'b1;
            end else begin
                mem_rd_dout_en = 1'b0;
                mem_rd_dout    = '0;
            end
            #1;
            if (ack) ack_cyc.push_back(cyc);
            if (mem_rd_en) begin
                if (first_en < 0) first_en = cyc;
                check_eq("issue_below_limit", DW'(tb_out < MAX_OUT), DW'(1));
                if (mem_rd_rdy) begin
                    cmd_q.push_back(mem_rd_addr);
                    pend_addr.push_back(mem_rd_addr);
                    pend_due.push_back(cyc + lat_v);
                    last_cmd = cyc;
                    tb_out++;
                end
            end
            if (ret) tb_out--;
            if (dout_eop) check_eq("eop_with_en", DW'(dout_en), DW'(1));
            if (dout_en) begin
                beat_q.push_back(dout);
                eop_q.push_back(dout_eop);
                if (dout_eop) eop_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_all();
        cmd_q.delete(); beat_q.delete(); eop_q.delete();
        ack_cyc.delete(); eop_cyc.delete();
        exp_cmd.delete(); exp_dat.delete(); exp_eop.delete();
        first_en = -1;
        last_cmd = -1;
    endtask

    // Reference: a transfer of len beats from a yields len consecutive
    // addresses modulo 2^AW, the memory contents there, eop on the last.
    task automatic expect_xfer(input logic [AW-1:0] a, input int len);
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] ai;
            ai = a + AW'(i);
            exp_cmd.push_back(ai);
            exp_dat.push_back(mem_data(ai));
            exp_eop.push_back(i == len - 1);
        end
    endtask

    task automatic wait_ack(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #2;
            if (ack) seen = 1'b1;
        end
        check_eq({nm, "_ack_seen"}, DW'(seen), DW'(1));
    endtask

    task automatic wait_beats(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (beat_q.size() < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        check_eq({nm, "_beats_in_time"}, DW'(beat_q.size() >= n), DW'(1));
    endtask

    task automatic verify(input string nm);
        check_eq({nm, "_cmd_count"}, DW'(cmd_q.size()), DW'(exp_cmd.size()));
        check_eq({nm, "_beat_count"}, DW'(beat_q.size()), DW'(exp_dat.size()));
        for (int i = 0; i < exp_cmd.size() && i < cmd_q.size(); i++)
            check_eq($sformatf("%s_addr%0d", nm, i), DW'(cmd_q[i]), DW'(exp_cmd[i]));
        for (int i = 0; i < exp_dat.size() && i < beat_q.size(); i++) begin
            check_eq($sformatf("%s_data%0d", nm, i), beat_q[i], exp_dat[i]);
            check_eq($sformatf("%s_eop%0d", nm, i), DW'(eop_q[i]), DW'(exp_eop[i]));
        end
    endtask

    task automatic do_xfer(input logic [AW-1:0] a, input int len, input int lat, input bit rr,
                           input string nm);
        int r;
        clear_all();
        expect_xfer(a, len);
        lat_v    = lat;
        rdy_rand = rr;
        @(posedge clk); #2;
        start_addr = a;
        length     = AW'(len);
        req        = 1'b1;
        r          = cyc;
        wait_ack(nm);
        @(posedge clk); #2;
        req = 1'b0;
        wait_beats(nm, len, len * (lat + 4) * 3 + 200);
        repeat (lat + 6) @(posedge clk);
        #2;
        check_eq({nm, "_ack_count"}, DW'(ack_cyc.size()), DW'(1));
        if (ack_cyc.size() > 0) check_eq({nm, "_ack_cycle"}, DW'(ack_cyc[0]), DW'(r + 1));
        check_eq({nm, "_first_en_cycle"}, DW'(first_en), DW'(r + 2));
        if (!rr && lat < MAX_OUT - 1)
            check_eq({nm, "_throughput"}, DW'(last_cmd - first_en), DW'(len - 1));
        verify(nm);
    endtask

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_ack", DW'(ack), DW'(0));
        check_eq("rst_dout_en", DW'(dout_en), DW'(0));
        check_eq("rst_eop", DW'(dout_eop), DW'(0));
        check_eq("rst_mem_rd_en", DW'(mem_rd_en), DW'(0));
        check_eq("rst_mem_rd_addr", DW'(mem_rd_addr), DW'(0));
        check_eq("rst_dout", dout, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic streaming transfer.
        do_xfer(27'd452, 50, 1, 1'b0, "basic");
        // Long latency with random ready: hits the outstanding limit.
        do_xfer(27'd9000, 30, 20, 1'b1, "latency");
        // Single beat at the top address.
        do_xfer(27'h7FF_FFFF, 1, 2, 1'b0, "top");
        // Wrap past the top address.
        do_xfer(27'h7FF_FFFE, 4, 3, 1'b1, "wrap");

        // Zero length with req held: ack, IDLE two cycles later, ack again.
        clear_all();
        @(posedge clk); #2;
        start_addr = 27'd123;
        length     = 27'd0;
        req        = 1'b1;
        r          = cyc;
        for (int i = 0; i < 10 && ack_cyc.size() < 2; i++) begin
            @(posedge clk); #2;
        end
        req = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("len0_ack_count", DW'(ack_cyc.size()), DW'(2));
        if (ack_cyc.size() >= 2) begin
            check_eq("len0_ack0_cycle", DW'(ack_cyc[0]), DW'(r + 1));
            check_eq("len0_ack1_cycle", DW'(ack_cyc[1]), DW'(r + 3));
        end
        check_eq("len0_no_rd_en", DW'(first_en), DW'(-1));
        check_eq("len0_no_beats", DW'(beat_q.size()), DW'(0));
        check_eq("len0_no_eop", DW'(eop_cyc.size()), DW'(0));

        // req held through a 3-beat transfer; second uses updated fields.
        clear_all();
        expect_xfer(27'd300, 3);
        expect_xfer(27'd5000, 5);
        lat_v    = 2;
        rdy_rand = 1'b0;
        @(posedge clk); #2;
        start_addr = 27'd300;
        length     = 27'd3;
        req        = 1'b1;
        wait_ack("hold1");
        @(posedge clk); #2;
        start_addr = 27'd5000;
        length     = 27'd5;
        for (int i = 0; i < 100 && ack_cyc.size() < 2; i++) begin
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        req = 1'b0;
        wait_beats("hold", 8, 200);
        repeat (8) @(posedge clk);
        #2;
        check_eq("hold_ack_count", DW'(ack_cyc.size()), DW'(2));
        if (ack_cyc.size() >= 2 && eop_cyc.size() >= 1)
            check_eq("hold_ack2_after_eop", DW'(ack_cyc[1]), DW'(eop_cyc[0] + 2));
        check_eq("hold_eop_count", DW'(eop_cyc.size()), DW'(2));
        verify("hold");

        // Reset after 10 of 40 beats, then a fresh 4-beat transfer.
        clear_all();
        lat_v    = 3;
        rdy_rand = 1'b0;
        @(posedge clk); #2;
        start_addr = 27'd1000;
        length     = 27'd40;
        req        = 1'b1;
        wait_ack("rst_mid");
        @(posedge clk); #2;
        req = 1'b0;
        wait_beats("rst_mid", 10, 200);
        rst = 1'b1;
        @(posedge clk); #2;
        check_eq("mid_rst_ack", DW'(ack), DW'(0));
        check_eq("mid_rst_dout_en", DW'(dout_en), DW'(0));
        check_eq("mid_rst_eop", DW'(dout_eop), DW'(0));
        check_eq("mid_rst_mem_rd_en", DW'(mem_rd_en), DW'(0));
        check_eq("mid_rst_mem_rd_addr", DW'(mem_rd_addr), DW'(0));
        check_eq("mid_rst_dout", dout, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        do_xfer(27'd777, 4, 2, 1'b0, "post_rst");

        // Randomized transfers.
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            if ($urandom_range(0, 3) == 0) a = 27'h7FF_FFFF - AW'($urandom_range(0, 5));
            do_xfer(a, int'($urandom_range(1, 24)), int'($urandom_range(1, 8)),
                    1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_read_engine.md
# dma_read_engine

Responder side of the `dma_engineer_*` weight-fetch interface used by the conv layers. It accepts a single request carrying a start address and a beat count from a layer controller. It issues 512-bit reads to the external memory port and streams the returned beats back as `dma_engineer_dout` with `dma_engineer_dout_en` and a last-beat `dma_engineer_dout_eop`. One instance serves one layer; arbitration between layers sits upstream.

## Interface
- `ADDR_W`, 27: width of start address and length (units of 512-bit beats).
- `DATA_W`, 512: beat width.
- `MAX_OUTSTANDING`, 8: maximum memory reads issued but not yet returned (power of two, ≥2).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `dma_engineer_req` in 1: request, level; held until `dma_engineer_ack` is seen.
- `dma_engineer_start_addr` in ADDR_W: first beat address, valid while `req`.
- `dma_engineer_length` in ADDR_W: number of beats, valid while `req`.
- `dma_engineer_ack` out 1: one-cycle pulse; request accepted.
- `dma_engineer_dout` out DATA_W: returned beat.
- `dma_engineer_dout_en` out 1: `dout` valid this cycle (no backpressure).
- `dma_engineer_dout_eop` out 1: with `dout_en`, marks the final beat.
- `mem_rd_en` out 1: read command valid.
- `mem_rd_rdy` in 1: memory accepts the command when `mem_rd_en && mem_rd_rdy`.
- `mem_rd_addr` out ADDR_W: read beat address.
- `mem_rd_dout_en` in 1: read data valid, in issue order.
- `mem_rd_dout` in DATA_W: read data.

## Operation
- States: IDLE, ACK, ISSUE, DRAIN.
- IDLE: when `req`=1, latch `start_addr` into `addr_q` and `length` into `remain_q` and `beats_q`. Go to ACK.
- ACK: `ack`=1 for this cycle only. Go to ISSUE, or to IDLE if the latched length is 0. A zero-length request produces no beats and no eop.
- ISSUE: `mem_rd_en`=1 when `remain_q`≠0 and `outstanding < MAX_OUTSTANDING`. On each accept: increment `addr_q` and decrement `remain_q`. Go to DRAIN once the last command is accepted.
- DRAIN: wait for the returned-beat count to reach `beats_q`, then go to IDLE.
- `req` is ignored outside IDLE. The requester drops `req` the cycle after `ack`. A `req` still high in the first IDLE cycle after DRAIN starts a new transfer.
- `outstanding` counter:
  - +1 on command accept, −1 on `mem_rd_dout_en`; both in the same cycle leave it unchanged.
  - Width is log2(MAX_OUTSTANDING)+1.
  - It never exceeds MAX_OUTSTANDING.
- Beat counter `rx_cnt` (ADDR_W) counts returned beats. eop is asserted on the beat where `rx_cnt == beats_q-1`.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top address is silent.
- `mem_rd_dout_en` while in IDLE or ACK is dropped (`dout_en` forced 0).
- Reset mid-transfer returns to IDLE and clears all counters. The memory is reset by the same `rst`, so in-flight responses are discarded.

## Timing
- Reset values: `ack`=0, `dout_en`=0, `dout_eop`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `dout`=0.
- `req` rising in IDLE gives `ack` at cycle +1 and the first `mem_rd_en` at cycle +2.
- Command throughput is one per cycle while `mem_rd_rdy`=1 and the outstanding limit is not reached.
- Output latency from `mem_rd_dout_en` to `dma_engineer_dout_en` is set by the macro below.
- IDLE is re-entered in the cycle after the eop beat is counted, so back-to-back transfers have a 2-cycle gap before the next `ack`.

## Configuration
- `DMA_OUTPUT_REG_EN` defined:
  - `dout`, `dout_en` and `dout_eop` are registered.
  - Latency is 1 cycle from `mem_rd_dout_en`.
  - DRAIN exits one cycle later, after the registered eop beat has been emitted.
- `DMA_OUTPUT_REG_EN` undefined:
  - `dout` = `mem_rd_dout`, and `dout_en` = `mem_rd_dout_en` gated by state; 0-cycle combinational path.
  - `dout_eop` is decoded combinationally from `rx_cnt`.

## Test plan
- Start 452, length 50, `mem_rd_rdy`=1, memory with 1-cycle return:
  - exactly one `ack` pulse;
  - addresses 452..501 in order;
  - 50 `dout_en` beats, with eop only on the 50th;
  - data matches memory.
- `mem_rd_rdy` toggling randomly and memory latency 20 cycles, length 30:
  - `outstanding` never exceeds 8;
  - no command is issued while outstanding = 8;
  - all 30 beats return in order, with a single eop.
- Length 0:
  - `ack` pulses once;
  - no `mem_rd_en`, no `dout_en`, no eop;
  - back in IDLE 2 cycles after `req`.
- Length 1 at address 2^27−1:
  - single read at 0x7FFFFFF;
  - one beat with `dout_en`=`dout_eop`=1.
- `rst` asserted after 10 of 40 beats:
  - all outputs 0 the next cycle;
  - a new request with length 4 completes with exactly 4 beats.
- `req` held high through a transfer of 3 beats:
  - second `ack` only after the first eop;
  - second transfer uses the then-current address and length.
